// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - instruction fetch front end with prefetch FIFO and redirect flush
// Optional feature macro: IF_ALIGN_CHECK_EN (aligns redirect targets and flags misalignment)
module if_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_IF,
   output logic [31:0] PC_Addr_IF,
   output logic        inst_valid,
   output logic        fetch_misalign
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
   logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pca_q, pca_d;

   logic [31:0]   aq_mem [DEPTH];
   logic [31:0]   fd_mem [DEPTH];
   logic [31:0]   fa_mem [DEPTH];

   logic [CW:0]   occ;
   logic [CW-1:0] remain;
   logic [31:0]   rsp_addr;
   logic [31:0]   redir_pc;
   logic          grant, resp, drop_now, push, pop;

   // Outstanding requests plus buffered words share DEPTH, so the FIFO cannot overflow.
   assign occ      = {1'b0, out_q} + {1'b0, cnt_q};
   assign imem_req = rst && !redirect && (occ < (CW+1)'(DEPTH));
   assign grant    = imem_req && imem_gnt;
   assign resp     = imem_rvalid;
   assign rsp_addr = aq_mem[aq_rd_q];
   assign drop_now = resp && (drop_q != '0);
   assign push     = resp && !drop_now && !redirect;
   assign pop      = inst_valid && !stall && !redirect;

   assign imem_addr      = pc_q;
   assign inst_valid     = (cnt_q != '0);
   assign Instruction_IF = instr_q;
   assign PC_Addr_IF     = pca_q;

`ifdef IF_ALIGN_CHECK_EN
   logic mis_q, mis_d;
   assign redir_pc       = {redirect_addr[31:2], 2'b00};
   assign mis_d          = mis_q | (redirect && (redirect_addr[1:0] != 2'b00));
   assign fetch_misalign = mis_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mis_q <= 1'b0;
      else      mis_q <= mis_d;
   end
`else
   assign redir_pc       = redirect_addr;
   assign fetch_misalign = 1'b0;
`endif

   always_comb begin
      pc_d    = pc_q;
      out_d   = out_q + CW'(grant) - CW'(resp);
      drop_d  = drop_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      aq_wr_d = aq_wr_q + AW'(grant);
      aq_rd_d = aq_rd_q + AW'(resp);
      f_wr_d  = f_wr_q + AW'(push);
      f_rd_d  = f_rd_q + AW'(pop);
      remain  = cnt_q - CW'(pop);
      instr_d = instr_q;
      pca_d   = pca_q;

      if (redirect) begin
         // Everything still in flight after this cycle's response belongs to the old path.
         pc_d   = redir_pc;
         drop_d = out_q - CW'(resp);
         cnt_d  = '0;
         f_wr_d = '0;
         f_rd_d = '0;
      end else begin
         if (grant)    pc_d   = pc_q + 32'd4;
         if (drop_now) drop_d = drop_q - CW'(1);
         if (remain != '0) begin
            instr_d = fd_mem[f_rd_d];
            pca_d   = fa_mem[f_rd_d];
         end else if (push) begin
            instr_d = imem_rdata;
            pca_d   = rsp_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         out_q   <= '0;
         cnt_q   <= '0;
         drop_q  <= '0;
         aq_wr_q <= '0;
         aq_rd_q <= '0;
         f_wr_q  <= '0;
         f_rd_q  <= '0;
         instr_q <= '0;
         pca_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         aq_wr_q <= aq_wr_d;
         aq_rd_q <= aq_rd_d;
         f_wr_q  <= f_wr_d;
         f_rd_q  <= f_rd_d;
         instr_q <= instr_d;
         pca_q   <= pca_d;
      end
   end

   always_ff @(posedge clk) begin
      if (grant) aq_mem[aq_wr_q] <= pc_q;
      if (push) begin
         fd_mem[f_wr_q] <= imem_rdata;
         fa_mem[f_wr_q] <= rsp_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push && !pop) assert (cnt_q < CW'(DEPTH));
      if (rst && grant && !resp) assert (out_q < CW'(DEPTH));
   end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - directed self-checking bench for if_prefetch_unit
module tb_if_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction_IF;
   logic [31:0] PC_Addr_IF;
   logic        inst_valid;
   logic        fetch_misalign;

   int nchecks = 0;
   int nfail   = 0;
   int cyc     = 0;
   int lat     = 1;
   logic        mem_ready;
   logic        last_req;
   logic [31:0] last_addr;
   logic [31:0] q_addr [$];
   int          q_due  [$];
   logic [31:0] glog   [$];
   logic        found;

   if_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_addr  (redirect_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .Instruction_IF (Instruction_IF),
      .PC_Addr_IF     (PC_Addr_IF),
      .inst_valid     (inst_valid),
      .fetch_misalign (fetch_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step();
      imem_rvalid = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ~q_addr[0];
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end
      #1;
      last_req  = imem_req;
      last_addr = imem_addr;
      imem_gnt  = mem_ready && imem_req;
      if (imem_gnt) begin
         q_addr.push_back(imem_addr);
         q_due.push_back(cyc + lat);
         glog.push_back(imem_addr);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      q_addr.delete();
      q_due.delete();
      glog.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (inst_valid) found = 1'b1;
         else step();
      end
      check({tag, "_found"}, 32'(found), 32'd1);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; mem_ready = 1'b1;
      @(negedge clk);
      #1;
      check("rst_valid",  32'(inst_valid), 32'd0);
      check("rst_instr",  Instruction_IF, 32'd0);
      check("rst_pc",     PC_Addr_IF, 32'd0);
      check("rst_req",    32'(imem_req), 32'd0);
      check("rst_mis",    32'(fetch_misalign), 32'd0);
      check("rst_addr",   imem_addr, 32'd0);

      // Streaming: grant every cycle, 1-cycle latency.
      do_reset();
      lat = 1;
      check("seq_v0", 32'(inst_valid), 32'd0);
      step();
      check("seq_v1", 32'(inst_valid), 32'd0);
      step();
      check("seq_v2", 32'(inst_valid), 32'd1);
      check("seq_pc0", PC_Addr_IF, 32'd0);
      check("seq_in0", Instruction_IF, ~32'd0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check("seq_pc", PC_Addr_IF, 32'(4 * i));
         check("seq_in", Instruction_IF, ~32'(4 * i));
      end
      for (int i = 0; i < 6; i++) check("seq_gnt", glog[i], 32'(4 * i));

      // Fill under stall, then asynchronous reset mid-cycle.
      stall = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("full_req", 32'(last_req), 32'd0);
      check("full_valid", 32'(inst_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_valid", 32'(inst_valid), 32'd0);
      check("arst_instr", Instruction_IF, 32'd0);
      check("arst_pc",    PC_Addr_IF, 32'd0);
      check("arst_req",   32'(imem_req), 32'd0);
      check("arst_addr",  imem_addr, 32'd0);
      @(negedge clk);
      q_addr.delete(); q_due.delete(); glog.delete();
      rst = 1'b1;
      #1;
      check("arst_rel_addr", imem_addr, 32'd0);
      check("arst_rel_req",  32'(imem_req), 32'd1);
      #1;

      // Stall from reset: exactly DEPTH grants, then drain with no bubbles.
      @(negedge clk);
      for (int i = 0; i < 8; i++) step();
      check("stall_ngnt", 32'(glog.size()), 32'd4);
      check("stall_gnt3", glog[3], 32'h0000_000C);
      check("stall_req",  32'(last_req), 32'd0);
      check("stall_pc",   PC_Addr_IF, 32'd0);
      stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("drain_valid", 32'(inst_valid), 32'd1);
         check("drain_pc", PC_Addr_IF, 32'(4 * i));
         step();
      end
      check("drain_resume", glog[4], 32'h0000_0010);

      // Redirect with three slow fetches in flight.
      do_reset();
      lat = 5;
      for (int i = 0; i < 3; i++) step();
      redirect = 1'b1; redirect_addr = 32'h0000_0100;
      step();
      check("redir_req", 32'(last_req), 32'd0);
      check("redir_valid", 32'(inst_valid), 32'd0);
      redirect = 1'b0;
      step();
      check("redir_addr", last_addr, 32'h0000_0100);
      wait_valid("redir");
      check("redir_pc",    PC_Addr_IF, 32'h0000_0100);
      check("redir_instr", Instruction_IF, ~32'h0000_0100);

      // Misaligned redirect target.
      redirect = 1'b1; redirect_addr = 32'h0000_0202;
      step();
      redirect = 1'b0;
      step();
`ifdef IF_ALIGN_CHECK_EN
      check("mis_addr", last_addr, 32'h0000_0200);
      check("mis_flag", 32'(fetch_misalign), 32'd1);
`else
      check("mis_addr", last_addr, 32'h0000_0202);
      check("mis_flag", 32'(fetch_misalign), 32'd0);
`endif

      // Redirect coinciding with a response and a pop.
      do_reset();
      lat = 2;
      for (int i = 0; i < 3; i++) step();
      check("rp_valid", 32'(inst_valid), 32'd1);
      check("rp_pc", PC_Addr_IF, 32'd0);
      redirect = 1'b1; redirect_addr = 32'h0000_0300;
      step();
      check("rp_flush", 32'(inst_valid), 32'd0);
      redirect = 1'b0;
      wait_valid("rp");
      check("rp_first_pc", PC_Addr_IF, 32'h0000_0300);

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end

endmodule
